hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline hazard and sequencing controller for the 5-stage RV32IM core. It detects load-use hazards against the ID stage's source registers and flushes IF/ID and ID/EX on taken branches/jumps resolved in EX. It sequences the multi-cycle divide unit (DIV/DIVU/REM/REMU) with a start/done handshake, holding the front of the pipeline until the result is ready. It sits beside id_stage and drives the stall, flush and bubble controls of the PC, IF/ID and ID/EX registers.

Parameters:
MDU_TIMEOUT, 64, max cycles spent in MDU_WAIT before forced release (must be ≥2)
STALL_CNT_W, 32, width of the stall-cycle performance counter

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
id_rs1_addr  in  5  rs1 field of the instruction in ID
id_rs2_addr  in  5  rs2 field of the instruction in ID
id_uses_rs1  in  1  instruction in ID reads rs1
id_uses_rs2  in  1  instruction in ID reads rs2
ex_mem_read  in  1  instruction in EX is a load
ex_rd_addr  in  5  destination of the instruction in EX
ex_is_div  in  1  instruction in EX is a valid divide/remainder op
ex_branch_taken  in  1  taken branch/JAL/JALR resolved in EX
mdu_done  in  1  divider result valid (1-cycle pulse)
pc_stall  out  1  hold PC
ifid_stall  out  1  hold IF/ID
ifid_flush  out  1  clear IF/ID to NOP
idex_hold  out  1  hold ID/EX (keep EX instruction)
idex_bubble  out  1  load NOP into ID/EX
exmem_bubble  out  1  load NOP into EX/MEM
mdu_start  out  1  start divider (1-cycle pulse)
mdu_err  out  1  sticky timeout flag
stall_cnt  out  STALL_CNT_W  saturating count of cycles with pc_stall=1

Behaviour:
- States: RUN, MDU_WAIT (2-bit encoding, constants in package). Reset -> RUN, wait counter 0, mdu_err 0, stall_cnt 0. All control outputs are combinational from state and inputs; during and immediately after reset all equal 0.
- load_use = ex_mem_read & (ex_rd_addr != 0) & ((id_uses_rs1 & rs1==ex_rd) | (id_uses_rs2 & rs2==ex_rd)).
- Priority in RUN: ex_branch_taken > ex_is_div > load_use.
- RUN, ex_branch_taken: ifid_flush=1, idex_bubble=1; no stall; ex_is_div and load_use ignored this cycle. Stays RUN.
- RUN, ex_is_div: mdu_start=1; pc_stall, ifid_stall, idex_hold, exmem_bubble = 1; next state MDU_WAIT, wait counter cleared to 1.
- RUN, load_use only: pc_stall=1, ifid_stall=1, idex_bubble=1 for exactly that cycle (1-cycle stall; the next cycle the load is in MEM and forwarding covers it).
- RUN, none: all outputs 0. mdu_done in RUN is ignored.
- MDU_WAIT, mdu_done=0, counter < MDU_TIMEOUT: pc_stall, ifid_stall, idex_hold, exmem_bubble = 1; counter increments; mdu_start=0; load_use and ex_branch_taken ignored.
- MDU_WAIT, mdu_done=1: all holds 0 that cycle (divide result latches into EX/MEM, pipeline advances); next state RUN. Because the pipeline advances, the same divide cannot retrigger.
- MDU_WAIT, counter == MDU_TIMEOUT with no done: set mdu_err (sticky until rst), release the holds as for done, next state RUN.
- mdu_done and timeout in the same cycle: treated as done; mdu_err is not set.
- stall_cnt: +1 on each cycle with pc_stall=1; saturates at all-ones, no wrap.
- rst asserted mid-MDU_WAIT: next cycle RUN with outputs 0. The divider shares rst, so no cancel handshake exists.

Decomposition:
- Package hazard_pkg: state encoding constants (ST_RUN, ST_MDU_WAIT), REG_X0 constant (5'd0).
- Sub-module hazard_load_use_det: combinational comparator producing load_use. The FSM, counters and output mux stay in hazard_ctrl.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> one cycle of pc_stall=ifid_stall=idex_bubble=1; stall_cnt 0->1.
- x0 and unused operands: ex_rd=0 with rs1=0, or a match with id_uses_rs1=0 -> no stall.
- Divide: ex_is_div=1 at T0, mdu_done at T5 -> mdu_start only at T0; holds high T0..T4, low at T5; RUN at T6; stall_cnt=5.
- Branch priority: ex_branch_taken=1 together with load_use=1 and ex_is_div=1 in RUN -> ifid_flush=idex_bubble=1, mdu_start=0, pc_stall=0.
- Timeout: MDU_TIMEOUT=4, no done -> holds for 4 cycles, then release; mdu_err=1 and stays 1 until rst.
- Reset mid-wait: rst at cycle 3 of MDU_WAIT -> next cycle all outputs 0, stall_cnt=0, mdu_err=0; a new ex_is_div then re-pulses mdu_start.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard / divide sequencing controller.
package hazard_pkg;

    // Controller state encoding (2-bit to leave room for future states)
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MDU_WAIT = 2'd1;

    // Architectural zero register: never a real producer
    localparam logic [4:0] REG_X0 = 5'd0;

    // Front-of-pipe control bundle, one bit per register-control line
    typedef struct packed {
        logic pc_stall;
        logic ifid_stall;
        logic ifid_flush;
        logic idex_hold;
        logic idex_bubble;
        logic exmem_bubble;
        logic mdu_start;
    } hz_ctl_t;

    // Canned control patterns used by the FSM output mux
    localparam hz_ctl_t CTL_NONE     = 7'b000_0000;
    localparam hz_ctl_t CTL_LOAD_USE = 7'b110_0100; // stall PC/IF-ID, bubble ID/EX
    localparam hz_ctl_t CTL_BRANCH   = 7'b001_0100; // flush IF/ID, bubble ID/EX
    localparam hz_ctl_t CTL_MDU_HOLD = 7'b110_1010; // freeze front, keep div in EX
    localparam hz_ctl_t CTL_MDU_GO   = 7'b110_1011; // hold plus divider start pulse

endpackage

// File: rtl/hazard_load_use_det.sv
// Load-use hazard comparator: the load in EX writes a register that ID reads.
module hazard_load_use_det
    import hazard_pkg::*;
(
    input  logic [4:0] i_id_rs1_addr,
    input  logic [4:0] i_id_rs2_addr,
    input  logic       i_id_uses_rs1,
    input  logic       i_id_uses_rs2,
    input  logic       i_ex_mem_read,
    input  logic [4:0] i_ex_rd_addr,
    output logic       o_load_use
);

    logic w_rd_live;
    logic w_rs1_hit;
    logic w_rs2_hit;

    // A load into x0 produces nothing, so it can never cause a hazard
    assign w_rd_live = i_ex_mem_read && (i_ex_rd_addr != REG_X0);

    // Only operands the ID instruction actually reads may match
    assign w_rs1_hit = i_id_uses_rs1 && (i_id_rs1_addr == i_ex_rd_addr);
    assign w_rs2_hit = i_id_uses_rs2 && (i_id_rs2_addr == i_ex_rd_addr);

    assign o_load_use = w_rd_live && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller: load-use stalls, branch flushes and
// multi-cycle divide sequencing with a bounded wait and sticky timeout flag.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MDU_TIMEOUT = 64, // must be >= 2
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             id_rs1_addr,
    input  logic [4:0]             id_rs2_addr,
    input  logic                   id_uses_rs1,
    input  logic                   id_uses_rs2,
    input  logic                   ex_mem_read,
    input  logic [4:0]             ex_rd_addr,
    input  logic                   ex_is_div,
    input  logic                   ex_branch_taken,
    input  logic                   mdu_done,
    output logic                   pc_stall,
    output logic                   ifid_stall,
    output logic                   ifid_flush,
    output logic                   idex_hold,
    output logic                   idex_bubble,
    output logic                   exmem_bubble,
    output logic                   mdu_start,
    output logic                   mdu_err,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int WAIT_W = $clog2(MDU_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MDU_TIMEOUT);

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [WAIT_W-1:0]      r_wait_cnt;
    logic [WAIT_W-1:0]      w_wait_cnt_nxt;
    logic                   r_mdu_err;
    logic                   w_set_err;
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    logic                   w_load_use;
    hz_ctl_t                w_ctl;
    hz_ctl_t                w_ctl_out;

    hazard_load_use_det u_lu_det (
        .i_id_rs1_addr (id_rs1_addr),
        .i_id_rs2_addr (id_rs2_addr),
        .i_id_uses_rs1 (id_uses_rs1),
        .i_id_uses_rs2 (id_uses_rs2),
        .i_ex_mem_read (ex_mem_read),
        .i_ex_rd_addr  (ex_rd_addr),
        .o_load_use    (w_load_use)
    );

    // Next-state and control mux; branch beats divide beats load-use in RUN
    always_comb begin
        w_ctl          = CTL_NONE;
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_set_err      = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (ex_branch_taken) begin
                    // Wrong-path instructions in IF/ID and ID are squashed
                    w_ctl = CTL_BRANCH;
                end else if (ex_is_div) begin
                    w_ctl          = CTL_MDU_GO;
                    w_state_nxt    = ST_MDU_WAIT;
                    w_wait_cnt_nxt = WAIT_W'(1);
                end else if (w_load_use) begin
                    // One cycle is enough: next cycle the load sits in MEM
                    w_ctl = CTL_LOAD_USE;
                end
            end
            ST_MDU_WAIT: begin
                if (mdu_done) begin
                    // Result latches into EX/MEM; done wins over a coincident timeout
                    w_state_nxt = ST_RUN;
                end else if (r_wait_cnt >= TIMEOUT_VAL) begin
                    // Give up on the divider so the core cannot hang forever
                    w_set_err   = 1'b1;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_ctl          = CTL_MDU_HOLD;
                    w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Outputs are forced quiet while reset is held
    assign w_ctl_out = rst ? CTL_NONE : w_ctl;

    assign pc_stall     = w_ctl_out.pc_stall;
    assign ifid_stall   = w_ctl_out.ifid_stall;
    assign ifid_flush   = w_ctl_out.ifid_flush;
    assign idex_hold    = w_ctl_out.idex_hold;
    assign idex_bubble  = w_ctl_out.idex_bubble;
    assign exmem_bubble = w_ctl_out.exmem_bubble;
    assign mdu_start    = w_ctl_out.mdu_start;
    assign mdu_err      = r_mdu_err;
    assign stall_cnt    = r_stall_cnt;

    // State register and divide wait counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // Sticky divider-timeout flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mdu_err <= 1'b0;
        end else if (w_set_err) begin
            r_mdu_err <= 1'b1;
        end
    end

    // Saturating count of PC-stall cycles for performance monitoring
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_ctl_out.pc_stall && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus a randomized
// run compared against a cycle-level reference model of the controller rules.
module tb_hazard_ctrl;

    localparam int TO = 6;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    // Expected control patterns {pc_stall,ifid_stall,ifid_flush,idex_hold,idex_bubble,exmem_bubble,mdu_start}
    localparam logic [6:0] E_NONE = 7'b0000000;
    localparam logic [6:0] E_LU   = 7'b1100100;
    localparam logic [6:0] E_BR   = 7'b0010100;
    localparam logic [6:0] E_HOLD = 7'b1101010;
    localparam logic [6:0] E_GO   = 7'b1101011;

    logic          clk;
    logic          rst;
    logic [4:0]    id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic          id_uses_rs1, id_uses_rs2, ex_mem_read;
    logic          ex_is_div, ex_branch_taken, mdu_done;
    logic          pc_stall, ifid_stall, ifid_flush, idex_hold;
    logic          idex_bubble, exmem_bubble, mdu_start, mdu_err;
    logic [CW-1:0] stall_cnt;
    logic [6:0]    ctl;

    int n_pass  = 0;
    int n_total = 0;

    hazard_ctrl #(.MDU_TIMEOUT(TO), .STALL_CNT_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1_addr     (id_rs1_addr),
        .id_rs2_addr     (id_rs2_addr),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_mem_read     (ex_mem_read),
        .ex_rd_addr      (ex_rd_addr),
        .ex_is_div       (ex_is_div),
        .ex_branch_taken (ex_branch_taken),
        .mdu_done        (mdu_done),
        .pc_stall        (pc_stall),
        .ifid_stall      (ifid_stall),
        .ifid_flush      (ifid_flush),
        .idex_hold       (idex_hold),
        .idex_bubble     (idex_bubble),
        .exmem_bubble    (exmem_bubble),
        .mdu_start       (mdu_start),
        .mdu_err         (mdu_err),
        .stall_cnt       (stall_cnt)
    );

    assign ctl = {pc_stall, ifid_stall, ifid_flush, idex_hold, idex_bubble, exmem_bubble, mdu_start};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit br, input bit div, input bit done, input bit mr,
                          input logic [4:0] rd, input logic [4:0] rs1, input bit u1,
                          input logic [4:0] rs2, input bit u2);
        ex_branch_taken = br;
        ex_is_div       = div;
        mdu_done        = done;
        ex_mem_read     = mr;
        ex_rd_addr      = rd;
        id_rs1_addr     = rs1;
        id_uses_rs1     = u1;
        id_rs2_addr     = rs2;
        id_uses_rs2     = u2;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(1, 1, 1, 1, 5'd5, 5'd5, 1, 5'd5, 1);
        #1;
        n_total++;
        if (ctl !== E_NONE) $display("FAIL reset_during ctl=%b exp=%b", ctl, E_NONE); else n_pass++;
        cyc();
        cyc();
        rst = 1'b0;
        idle();
        #1;
        n_total++;
        if (ctl !== E_NONE) $display("FAIL reset_after ctl=%b exp=%b", ctl, E_NONE); else n_pass++;
        n_total++;
        if (stall_cnt !== 0) $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); else n_pass++;
        n_total++;
        if (mdu_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", mdu_err); else n_pass++;
    endtask

    task automatic test_load_use();
        do_reset();
        set_in(0, 0, 0, 1, 5'd5, 5'd1, 0, 5'd5, 1);
        #1;
        n_total++;
        if (ctl !== E_LU) $display("FAIL lu_stall ctl=%b exp=%b", ctl, E_LU); else n_pass++;
        cyc();
        idle();
        #1;
        n_total++;
        if (ctl !== E_NONE) $display("FAIL lu_release ctl=%b exp=%b", ctl, E_NONE); else n_pass++;
        n_total++;
        if (stall_cnt !== 1) $display("FAIL lu_cnt got=%0d exp=1", stall_cnt); else n_pass++;
    endtask

    task automatic test_x0_unused();
        do_reset();
        set_in(0, 0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 1);
        #1;
        n_total++;
        if (ctl !== E_NONE) $display("FAIL x0_no_stall ctl=%b exp=%b", ctl, E_NONE); else n_pass++;
        set_in(0, 0, 0, 1, 5'd7, 5'd7, 0, 5'd3, 1);
        #1;
        n_total++;
        if (ctl !== E_NONE) $display("FAIL unused_rs1 ctl=%b exp=%b", ctl, E_NONE); else n_pass++;
        set_in(0, 0, 0, 1, 5'd7, 5'd7, 1, 5'd3, 1);
        #1;
        n_total++;
        if (ctl !== E_LU) $display("FAIL rs1_match ctl=%b exp=%b", ctl, E_LU); else n_pass++;
        set_in(0, 0, 0, 0, 5'd7, 5'd7, 1, 5'd7, 1);
        #1;
        n_total++;
        if (ctl !== E_NONE) $display("FAIL not_load ctl=%b exp=%b", ctl, E_NONE); else n_pass++;
        idle();
    endtask

    task automatic test_divide();
        do_reset();
        set_in(0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        #1;
        n_total++;
        if (ctl !== E_GO) $display("FAIL div_t0 ctl=%b exp=%b", ctl, E_GO); else n_pass++;
        cyc();
        for (int t = 1; t <= 4; t++) begin
            // Branch and load-use presented mid-wait must be ignored
            set_in(t == 3, 1, 0, t == 2, 5'd4, 5'd4, 1, 5'd0, 0);
            #1;
            n_total++;
            if (ctl !== E_HOLD) $display("FAIL div_hold t=%0d ctl=%b exp=%b", t, ctl, E_HOLD); else n_pass++;
            cyc();
        end
        set_in(0, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        #1;
        n_total++;
        if (ctl !== E_NONE) $display("FAIL div_done ctl=%b exp=%b", ctl, E_NONE); else n_pass++;
        cyc();
        idle();
        #1;
        n_total++;
        if (ctl !== E_NONE) $display("FAIL div_after ctl=%b exp=%b", ctl, E_NONE); else n_pass++;
        n_total++;
        if (stall_cnt !== 5) $display("FAIL div_cnt got=%0d exp=5", stall_cnt); else n_pass++;
        set_in(0, 0, 0, 1, 5'd9, 5'd9, 1, 5'd0, 0);
        #1;
        n_total++;
        if (ctl !== E_LU) $display("FAIL div_back_in_run ctl=%b exp=%b", ctl, E_LU); else n_pass++;
        cyc();
        idle();
    endtask

    task automatic test_branch_priority();
        do_reset();
        set_in(1, 1, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0);
        #1;
        n_total++;
        if (ctl !== E_BR) $display("FAIL br_prio ctl=%b exp=%b", ctl, E_BR); else n_pass++;
        cyc();
        idle();
        #1;
        n_total++;
        if (ctl !== E_NONE) $display("FAIL br_stays_run ctl=%b exp=%b", ctl, E_NONE); else n_pass++;
        n_total++;
        if (stall_cnt !== 0) $display("FAIL br_cnt got=%0d exp=0", stall_cnt); else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset();
        set_in(0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        #1;
        n_total++;
        if (ctl !== E_GO) $display("FAIL to_t0 ctl=%b exp=%b", ctl, E_GO); else n_pass++;
        cyc();
        for (int t = 1; t < TO; t++) begin
            #1;
            n_total++;
            if (ctl !== E_HOLD) $display("FAIL to_hold t=%0d ctl=%b exp=%b", t, ctl, E_HOLD); else n_pass++;
            cyc();
        end
        #1;
        n_total++;
        if (ctl !== E_NONE) $display("FAIL to_release ctl=%b exp=%b", ctl, E_NONE); else n_pass++;
        cyc();
        idle();
        #1;
        n_total++;
        if (mdu_err !== 1'b1) $display("FAIL to_err_set got=%b exp=1", mdu_err); else n_pass++;
        n_total++;
        if (stall_cnt !== TO) $display("FAIL to_cnt got=%0d exp=%0d", stall_cnt, TO); else n_pass++;
        // A later, well-behaved divide must not clear the sticky flag
        set_in(0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        cyc();
        mdu_done = 1'b1;
        cyc();
        idle();
        cyc();
        #1;
        n_total++;
        if (mdu_err !== 1'b1) $display("FAIL to_err_sticky got=%b exp=1", mdu_err); else n_pass++;
        do_reset();
        #1;
        n_total++;
        if (mdu_err !== 1'b0) $display("FAIL to_err_clear got=%b exp=0", mdu_err); else n_pass++;
    endtask

    task automatic test_done_on_timeout();
        do_reset();
        set_in(0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        for (int t = 0; t < TO; t++) cyc();
        mdu_done = 1'b1;
        #1;
        n_total++;
        if (ctl !== E_NONE) $display("FAIL done_at_to ctl=%b exp=%b", ctl, E_NONE); else n_pass++;
        cyc();
        idle();
        #1;
        n_total++;
        if (mdu_err !== 1'b0) $display("FAIL done_at_to_err got=%b exp=0", mdu_err); else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        set_in(0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        for (int t = 0; t < 3; t++) cyc();
        rst = 1'b1;
        #1;
        n_total++;
        if (ctl !== E_NONE) $display("FAIL rmw_during ctl=%b exp=%b", ctl, E_NONE); else n_pass++;
        cyc();
        rst = 1'b0;
        idle();
        #1;
        n_total++;
        if (ctl !== E_NONE) $display("FAIL rmw_after ctl=%b exp=%b", ctl, E_NONE); else n_pass++;
        n_total++;
        if (stall_cnt !== 0 || mdu_err !== 1'b0)
            $display("FAIL rmw_regs cnt=%0d err=%b exp cnt=0 err=0", stall_cnt, mdu_err);
        else n_pass++;
        ex_is_div = 1'b1;
        #1;
        n_total++;
        if (ctl !== E_GO) $display("FAIL rmw_restart ctl=%b exp=%b", ctl, E_GO); else n_pass++;
        cyc();
        idle();
    endtask

    task automatic test_saturation();
        do_reset();
        set_in(0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        for (int t = 0; t < 30; t++) cyc();
        idle();
        #1;
        n_total++;
        if (stall_cnt !== CNT_MAX) $display("FAIL sat_cnt got=%0d exp=%0d", stall_cnt, CNT_MAX); else n_pass++;
    endtask

    // Reference: a divide "age" (cycles since its start) replaces any state encoding
    task automatic test_random();
        bit         waiting = 0;
        int         age = 0;
        bit         m_err = 0;
        int         m_cnt = 0;
        logic [6:0] exp;
        bit         lu;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) < 2);
            set_in($urandom_range(0, 99) < 15,
                   waiting ? ($urandom_range(0, 99) < 90) : ($urandom_range(0, 99) < 25),
                   $urandom_range(0, 99) < 15,
                   $urandom_range(0, 99) < 50,
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                   5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
            #1;
            lu = ex_mem_read && ex_rd_addr != 0 &&
                 ((id_uses_rs1 && id_rs1_addr == ex_rd_addr) || (id_uses_rs2 && id_rs2_addr == ex_rd_addr));
            if (rst)                exp = E_NONE;
            else if (waiting)       exp = (mdu_done || age >= TO) ? E_NONE : E_HOLD;
            else if (ex_branch_taken) exp = E_BR;
            else if (ex_is_div)     exp = E_GO;
            else if (lu)            exp = E_LU;
            else                    exp = E_NONE;
            n_total++;
            if (ctl !== exp) $display("FAIL rnd_ctl c=%0d ctl=%b exp=%b", c, ctl, exp); else n_pass++;
            n_total++;
            if (mdu_err !== m_err) $display("FAIL rnd_err c=%0d got=%b exp=%b", c, mdu_err, m_err); else n_pass++;
            n_total++;
            if (stall_cnt !== m_cnt) $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, stall_cnt, m_cnt); else n_pass++;
            if (rst) begin
                waiting = 0;
                m_err   = 0;
                m_cnt   = 0;
            end else begin
                if (exp[6] && m_cnt < CNT_MAX) m_cnt++;
                if (waiting) begin
                    if (mdu_done) waiting = 0;
                    else if (age >= TO) begin
                        waiting = 0;
                        m_err   = 1;
                    end else age++;
                end else if (!ex_branch_taken && ex_is_div) begin
                    waiting = 1;
                    age     = 1;
                end
            end
            cyc();
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_x0_unused();
        test_divide();
        test_branch_priority();
        test_timeout();
        test_done_on_timeout();
        test_reset_mid_wait();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
